pipeline_debug_ctrl: RTL and testbench

//   Run/step/halt sequencer for the 5-stage MIPS pipeline. Drives the global stall into IF/ID/EX/MEM/WB.

---
 rtl/mips_dbg_pkg.sv | 30 +++
 rtl/pipeline_debug_ctrl_if.sv | 41 ++++
 rtl/dbg_dump_streamer.sv | 78 +++++++
 rtl/pipeline_debug_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pipeline_debug_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_dbg_pkg.sv
// -----------------------------------------------------------------------------
// mips_dbg_pkg
//   Shared definitions for the pipeline debug path. The same encodings are used
//   by instruction_decode, the UART debug unit and pipeline_debug_ctrl.
//   Contents:
//     CMD_RUN/CMD_STEP/CMD_HALT/CMD_DUMP  2-bit debug command codes
//     state_t                             sequencer state encoding (o_state)
//     dump_len()                          number of words in one register dump
// -----------------------------------------------------------------------------
package mips_dbg_pkg;

    localparam logic [1:0] CMD_RUN  = 2'b00;
    localparam logic [1:0] CMD_STEP = 2'b01;
    localparam logic [1:0] CMD_HALT = 2'b10;
    localparam logic [1:0] CMD_DUMP = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        STEP  = 3'd2,
        DRAIN = 3'd3,
        DUMP  = 3'd4
    } state_t;

    // All GPRs, plus one trailing word when the cycle counter is appended.
    function automatic int dump_len(input int nb_addr, input bit cnt_en);
        return (1 << nb_addr) + (cnt_en ? 1 : 0);
    endfunction

endpackage

// File: rtl/pipeline_debug_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_debug_ctrl_if
//   Command and dump-stream handshakes between the UART debug unit (master)
//   and pipeline_debug_ctrl (slave). Signal prefixes are from the controller's
//   point of view.
//   Signals:
//     i_cmd_valid / i_cmd[1:0] / o_cmd_ready      command channel
//     o_dump_data / o_dump_valid / o_dump_last    dump word channel
//     i_dump_ready                                dump sink ready
// -----------------------------------------------------------------------------
interface pipeline_debug_ctrl_if #(
    parameter int NB_DATA = 32
);
    logic               i_cmd_valid;
    logic [1:0]         i_cmd;
    logic               o_cmd_ready;
    logic [NB_DATA-1:0] o_dump_data;
    logic               o_dump_valid;
    logic               o_dump_last;
    logic               i_dump_ready;

    modport slave (
        input  i_cmd_valid,
        input  i_cmd,
        input  i_dump_ready,
        output o_cmd_ready,
        output o_dump_data,
        output o_dump_valid,
        output o_dump_last
    );

    modport master (
        output i_cmd_valid,
        output i_cmd,
        output i_dump_ready,
        input  o_cmd_ready,
        input  o_dump_data,
        input  o_dump_valid,
        input  o_dump_last
    );
endinterface

// File: rtl/dbg_dump_streamer.sv
// -----------------------------------------------------------------------------
// dbg_dump_streamer
//   Walks the register file and streams each word through a single output
//   register with valid/ready/last. Words with index >= 2**NB_ADDR come from
//   i_extra_word instead of the register file.
//   Ports:
//     clk, i_rst_n      clock, async active-low reset
//     i_start           clear index/output register before a new dump
//     i_en              streamer active (controller in DUMP)
//     o_rd_addr         register-file read address (current index)
//     i_rd_data         register-file read data (combinational)
//     i_extra_word      word appended after the register file
//     i_dump_ready      sink ready
//     o_dump_data/valid/last  output register
//     o_done            final word accepted this cycle
// -----------------------------------------------------------------------------
module dbg_dump_streamer #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 5,
    parameter int N_WORDS = 32
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_en,
    output logic [NB_ADDR-1:0] o_rd_addr,
    input  logic [NB_DATA-1:0] i_rd_data,
    input  logic [NB_DATA-1:0] i_extra_word,
    input  logic               i_dump_ready,
    output logic [NB_DATA-1:0] o_dump_data,
    output logic               o_dump_valid,
    output logic               o_dump_last,
    output logic               o_done
);

    // One bit wider than the address so the index never wraps back to 0.
    localparam int NB_IDX = NB_ADDR + 1;

    logic [NB_IDX-1:0]  idx_q;
    logic               words_left;
    logic               is_final;
    logic               xfer;
    logic               load;
    logic [NB_DATA-1:0] word_in;

    assign words_left = (idx_q < NB_IDX'(N_WORDS));
    assign is_final   = (idx_q == NB_IDX'(N_WORDS - 1));
    assign xfer       = o_dump_valid && i_dump_ready;
    assign load       = i_en && words_left && (!o_dump_valid || i_dump_ready);
    assign word_in    = idx_q[NB_ADDR] ? i_extra_word : i_rd_data;
    assign o_rd_addr  = idx_q[NB_ADDR-1:0];
    assign o_done     = i_en && xfer && o_dump_last;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idx_q        <= '0;
            o_dump_data  <= '0;
            o_dump_valid <= 1'b0;
            o_dump_last  <= 1'b0;
        end else if (i_start) begin
            idx_q        <= '0;
            o_dump_valid <= 1'b0;
            o_dump_last  <= 1'b0;
        end else if (i_en) begin
            if (load) begin
                o_dump_data  <= word_in;
                o_dump_valid <= 1'b1;
                o_dump_last  <= is_final;
                idx_q        <= idx_q + NB_IDX'(1);
            end else if (xfer) begin
                // Accepted with nothing left to replace it (covers the last word).
                o_dump_valid <= 1'b0;
                o_dump_last  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipeline_debug_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_debug_ctrl
//   Run/step/halt sequencer for the 5-stage MIPS pipeline. Generates the fetch
//   hold and global pipeline stall, and while halted borrows register-file read
//   port 1 to stream all GPRs to the debug unit.
//   Build option: `PIPELINE_DEBUG_CYCLE_COUNT_EN adds an NB_CNT-bit counter of
//   unstalled cycles, appended as the final dump word.
//   Ports:
//     clk, i_rst_n     clock, async active-low reset
//     bus              command + dump stream (pipeline_debug_ctrl_if.slave)
//     i_halt_instr     ID decoded a HALT opcode
//     o_fetch_hold     freeze PC/IF
//     o_pipe_stall     freeze ID..WB pipeline registers
//     o_dbg_rd_en      read port 1 address taken from o_dbg_rd_addr
//     o_dbg_rd_addr    debug read address
//     i_dbg_rd_data    register-file read data
//     o_state          current state (state_t encoding)
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | halted; accepts RUN/STEP/DUMP, HALT is a no-op
//   RUN   | free running; HALT cmd or HALT opcode starts a drain
//   STEP  | one unstalled cycle, then IDLE (or DRAIN on HALT opcode)
//   DRAIN | fetch held, PIPE_DEPTH cycles to retire in-flight work
//   DUMP  | halted; GPRs (and optional counter) streamed out
// -----------------------------------------------------------------------------
module pipeline_debug_ctrl
    import mips_dbg_pkg::*;
#(
    parameter int NB_DATA    = 32,
    parameter int NB_ADDR    = 5,
    parameter int PIPE_DEPTH = 4,
    parameter int NB_CNT     = 32
) (
    input  logic                 clk,
    input  logic                 i_rst_n,
    pipeline_debug_ctrl_if.slave bus,
    input  logic                 i_halt_instr,
    output logic                 o_fetch_hold,
    output logic                 o_pipe_stall,
    output logic                 o_dbg_rd_en,
    output logic [NB_ADDR-1:0]   o_dbg_rd_addr,
    input  logic [NB_DATA-1:0]   i_dbg_rd_data,
    output logic [2:0]           o_state
);

    localparam int NB_DRAIN = $clog2(PIPE_DEPTH + 1);

    if (PIPE_DEPTH < 1 || NB_CNT < 1 || NB_ADDR < 1 || NB_DATA < 1) begin : g_param_check
        $error("pipeline_debug_ctrl: parameters must all be >= 1");
    end

    state_t              state_q, state_d;
    logic [NB_DRAIN-1:0] drain_q;
    logic                drain_load;
    logic                dump_start;
    logic                dump_done;
    logic [NB_ADDR-1:0]  stream_addr;
    logic [NB_DATA-1:0]  cnt_word;

`ifdef PIPELINE_DEBUG_CYCLE_COUNT_EN
    localparam bit CNT_EN = 1'b1;

    logic [NB_CNT-1:0] cyc_cnt_q;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cyc_cnt_q <= '0;
        end else if (!o_pipe_stall) begin
            cyc_cnt_q <= cyc_cnt_q + NB_CNT'(1);
        end
    end

    assign cnt_word = NB_DATA'(cyc_cnt_q);
`else
    localparam bit CNT_EN = 1'b0;

    assign cnt_word = '0;
`endif

    localparam int N_WORDS = dump_len(NB_ADDR, CNT_EN);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        o_fetch_hold    = 1'b1;
        o_pipe_stall    = 1'b1;
        bus.o_cmd_ready = 1'b0;
        o_dbg_rd_en     = 1'b0;
        drain_load      = 1'b0;
        dump_start      = 1'b0;

        case (state_q)
            IDLE: begin
                bus.o_cmd_ready = 1'b1;
                if (bus.i_cmd_valid) begin
                    case (bus.i_cmd)
                        CMD_RUN:  state_d = RUN;
                        CMD_STEP: state_d = STEP;
                        CMD_DUMP: begin
                            state_d    = DUMP;
                            dump_start = 1'b1;
                        end
                        default:  state_d = IDLE;
                    endcase
                end
            end
            RUN: begin
                o_fetch_hold    = 1'b0;
                o_pipe_stall    = 1'b0;
                bus.o_cmd_ready = 1'b1;
                // Any halt source wins over whatever else is on the command bus.
                if (i_halt_instr || (bus.i_cmd_valid && bus.i_cmd == CMD_HALT)) begin
                    state_d    = DRAIN;
                    drain_load = 1'b1;
                end
            end
            STEP: begin
                o_fetch_hold = 1'b0;
                o_pipe_stall = 1'b0;
                if (i_halt_instr) begin
                    state_d    = DRAIN;
                    drain_load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                o_pipe_stall = 1'b0;
                if (drain_q == NB_DRAIN'(1)) begin
                    state_d = IDLE;
                end
            end
            DUMP: begin
                o_dbg_rd_en = 1'b1;
                if (dump_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Loaded with PIPE_DEPTH on entry, so DRAIN lasts exactly PIPE_DEPTH cycles.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            drain_q <= '0;
        end else if (drain_load) begin
            drain_q <= NB_DRAIN'(PIPE_DEPTH);
        end else if (state_q == DRAIN) begin
            drain_q <= drain_q - NB_DRAIN'(1);
        end
    end

    dbg_dump_streamer #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR),
        .N_WORDS (N_WORDS)
    ) u_streamer (
        .clk          (clk),
        .i_rst_n      (i_rst_n),
        .i_start      (dump_start),
        .i_en         (state_q == DUMP),
        .o_rd_addr    (stream_addr),
        .i_rd_data    (i_dbg_rd_data),
        .i_extra_word (cnt_word),
        .i_dump_ready (bus.i_dump_ready),
        .o_dump_data  (bus.o_dump_data),
        .o_dump_valid (bus.o_dump_valid),
        .o_dump_last  (bus.o_dump_last),
        .o_done       (dump_done)
    );

    assign o_dbg_rd_addr = o_dbg_rd_en ? stream_addr : '0;
    assign o_state       = state_q;

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_debug_ctrl
//   Directed bench for pipeline_debug_ctrl. Control-path expectations are
//   checked inline; dump words go through a scoreboard queue filled when a DUMP
//   is issued and drained by an independent monitor on every accepted word.
// -----------------------------------------------------------------------------
module tb_pipeline_debug_ctrl;
    import mips_dbg_pkg::*;

    localparam int NB_DATA = 32;
    localparam int NB_ADDR = 5;
`ifdef PIPELINE_DEBUG_CYCLE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam int N_WORDS = 32 + (CNT_EN ? 1 : 0);

    logic               clk = 1'b0;
    logic               i_rst_n = 1'b0;
    logic               i_halt_instr;
    logic               o_fetch_hold;
    logic               o_pipe_stall;
    logic               o_dbg_rd_en;
    logic [NB_ADDR-1:0] o_dbg_rd_addr;
    logic [NB_DATA-1:0] i_dbg_rd_data;
    logic [2:0]         o_state;

    pipeline_debug_ctrl_if #(.NB_DATA(NB_DATA)) dbg_if ();

    pipeline_debug_ctrl #(
        .NB_DATA    (NB_DATA),
        .NB_ADDR    (NB_ADDR),
        .PIPE_DEPTH (4),
        .NB_CNT     (32)
    ) dut (
        .clk           (clk),
        .i_rst_n       (i_rst_n),
        .bus           (dbg_if),
        .i_halt_instr  (i_halt_instr),
        .o_fetch_hold  (o_fetch_hold),
        .o_pipe_stall  (o_pipe_stall),
        .o_dbg_rd_en   (o_dbg_rd_en),
        .o_dbg_rd_addr (o_dbg_rd_addr),
        .i_dbg_rd_data (i_dbg_rd_data),
        .o_state       (o_state)
    );

    always #5 clk = ~clk;

    logic [NB_DATA-1:0] regfile [32];
    assign i_dbg_rd_data = regfile[o_dbg_rd_addr];

    typedef struct packed {
        logic [NB_DATA-1:0] data;
        logic               last;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] c);
        dbg_if.i_cmd_valid = 1'b1;
        dbg_if.i_cmd       = c;
        tick();
        dbg_if.i_cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name, output int cycles);
        cycles = 0;
        while (o_state != 3'(IDLE) && cycles < budget) begin
            tick();
            cycles++;
        end
        chk(name, 32'(o_state), 32'(IDLE));
    endtask

    task automatic count_unstalled(output int n);
        n = 0;
        while (!o_pipe_stall && n < 20) begin
            n++;
            tick();
        end
    endtask

    task automatic push_dump(input logic [NB_DATA-1:0] cnt_word);
        exp_t e;
        for (int i = 0; i < 32; i++) begin
            e.data = 32'(i * 3);
            e.last = (i == 31) && !CNT_EN;
            sb_q.push_back(e);
        end
        if (CNT_EN) begin
            e.data = cnt_word;
            e.last = 1'b1;
            sb_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        tick();
        sb_q.delete();
        i_rst_n = 1'b1;
        tick();
    endtask

    // Scoreboard monitor: pops one expected word per accepted transfer and
    // checks that a stalled word stays frozen until it is taken.
    logic               prev_stalled = 1'b0;
    logic [NB_DATA-1:0] prev_data;
    logic               prev_last;

    always @(negedge clk) begin
        if (!i_rst_n) begin
            prev_stalled = 1'b0;
        end else begin
            if (prev_stalled) begin
                chk("hold_data",  dbg_if.o_dump_data, prev_data);
                chk("hold_valid", 32'(dbg_if.o_dump_valid), 32'd1);
                chk("hold_last",  32'(dbg_if.o_dump_last), 32'(prev_last));
            end
            if (dbg_if.o_dump_valid && dbg_if.i_dump_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL dump_unexpected_word actual=%0d expected=none",
                             dbg_if.o_dump_data);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("dump_data", dbg_if.o_dump_data, e.data);
                    chk("dump_last", 32'(dbg_if.o_dump_last), 32'(e.last));
                end
            end
            prev_stalled = dbg_if.o_dump_valid && !dbg_if.i_dump_ready;
            prev_data    = dbg_if.o_dump_data;
            prev_last    = dbg_if.o_dump_last;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        for (int i = 0; i < 32; i++) regfile[i] = 32'(i * 3);
        dbg_if.i_cmd_valid  = 1'b0;
        dbg_if.i_cmd        = 2'b00;
        dbg_if.i_dump_ready = 1'b0;
        i_halt_instr        = 1'b0;

        // Reset values
        #12;
        chk("rst_state",      32'(o_state), 32'(IDLE));
        chk("rst_pipe_stall", 32'(o_pipe_stall), 32'd1);
        chk("rst_fetch_hold", 32'(o_fetch_hold), 32'd1);
        chk("rst_valid",      32'(dbg_if.o_dump_valid), 32'd0);
        chk("rst_last",       32'(dbg_if.o_dump_last), 32'd0);
        chk("rst_rd_addr",    32'(o_dbg_rd_addr), 32'd0);
        chk("rst_cmd_ready",  32'(dbg_if.o_cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        i_rst_n = 1'b1;
        tick();

        // RUN releases both stalls on the next cycle; other cmds ignored in RUN
        send_cmd(CMD_RUN);
        chk("run_state",      32'(o_state), 32'(RUN));
        chk("run_pipe_stall", 32'(o_pipe_stall), 32'd0);
        chk("run_fetch_hold", 32'(o_fetch_hold), 32'd0);
        chk("run_cmd_ready",  32'(dbg_if.o_cmd_ready), 32'd1);
        send_cmd(CMD_STEP);
        chk("run_ignores_step", 32'(o_state), 32'(RUN));

        // HALT opcode -> 4 drain cycles -> IDLE
        tick();
        i_halt_instr = 1'b1;
        tick();
        i_halt_instr = 1'b0;
        chk("drain_state",      32'(o_state), 32'(DRAIN));
        chk("drain_fetch_hold", 32'(o_fetch_hold), 32'd1);
        chk("drain_cmd_ready",  32'(dbg_if.o_cmd_ready), 32'd0);
        count_unstalled(n);
        chk("drain_cycles", 32'(n), 32'd4);
        chk("drain_end_state", 32'(o_state), 32'(IDLE));
        chk("drain_end_fetch_hold", 32'(o_fetch_hold), 32'd1);

        // STEP: exactly one unstalled cycle, twice
        send_cmd(CMD_STEP);
        chk("step_state",     32'(o_state), 32'(STEP));
        chk("step_cmd_ready", 32'(dbg_if.o_cmd_ready), 32'd0);
        chk("step_fetch_hold", 32'(o_fetch_hold), 32'd0);
        count_unstalled(n);
        chk("step1_cycles", 32'(n), 32'd1);
        chk("step1_end_state", 32'(o_state), 32'(IDLE));
        send_cmd(CMD_STEP);
        count_unstalled(n);
        chk("step2_cycles", 32'(n), 32'd1);
        chk("step2_end_state", 32'(o_state), 32'(IDLE));

        // STEP hitting a HALT opcode drains
        send_cmd(CMD_STEP);
        i_halt_instr = 1'b1;
        tick();
        i_halt_instr = 1'b0;
        chk("step_halt_state", 32'(o_state), 32'(DRAIN));
        wait_idle(10, "step_halt_idle", n);

        // HALT from IDLE is a no-op
        send_cmd(CMD_HALT);
        chk("idle_halt_noop", 32'(o_state), 32'(IDLE));
        chk("idle_halt_stall", 32'(o_pipe_stall), 32'd1);

        // HALT command from RUN
        send_cmd(CMD_RUN);
        tick();
        send_cmd(CMD_HALT);
        chk("halt_cmd_state", 32'(o_state), 32'(DRAIN));
        wait_idle(10, "halt_cmd_idle", n);

        // RUN cmd and HALT opcode in the same cycle: halt wins
        send_cmd(CMD_RUN);
        i_halt_instr = 1'b1;
        send_cmd(CMD_RUN);
        i_halt_instr = 1'b0;
        chk("run_vs_halt_state", 32'(o_state), 32'(DRAIN));
        wait_idle(10, "run_vs_halt_idle", n);

        // Full dump, ready held high (counter cleared by reset)
        do_reset();
        dbg_if.i_dump_ready = 1'b1;
        push_dump(32'd0);
        send_cmd(CMD_DUMP);
        chk("dump_state",      32'(o_state), 32'(DUMP));
        chk("dump_rd_en",      32'(o_dbg_rd_en), 32'd1);
        chk("dump_first_gap",  32'(dbg_if.o_dump_valid), 32'd0);
        chk("dump_pipe_stall", 32'(o_pipe_stall), 32'd1);
        chk("dump_cmd_ready",  32'(dbg_if.o_cmd_ready), 32'd0);
        tick();
        chk("dump_first_valid", 32'(dbg_if.o_dump_valid), 32'd1);
        wait_idle(100, "dump_done_idle", n);
        chk("dump_cycles",     32'(n), 32'(N_WORDS));
        chk("dump_all_words",  32'(sb_q.size()), 32'd0);
        chk("dump_rd_en_off",  32'(o_dbg_rd_en), 32'd0);
        chk("dump_valid_off",  32'(dbg_if.o_dump_valid), 32'd0);

        // Dump with ready toggling every cycle
        push_dump(32'd0);
        send_cmd(CMD_DUMP);
        n = 0;
        while (o_state != 3'(IDLE) && n < 300) begin
            dbg_if.i_dump_ready = ~dbg_if.i_dump_ready;
            tick();
            n++;
        end
        chk("bp_dump_idle",  32'(o_state), 32'(IDLE));
        chk("bp_all_words",  32'(sb_q.size()), 32'd0);

        // Reset in the middle of a dump
        dbg_if.i_dump_ready = 1'b1;
        push_dump(32'd0);
        send_cmd(CMD_DUMP);
        repeat (5) tick();
        i_rst_n = 1'b0;
        #1;
        chk("midrst_valid",   32'(dbg_if.o_dump_valid), 32'd0);
        chk("midrst_last",    32'(dbg_if.o_dump_last), 32'd0);
        chk("midrst_state",   32'(o_state), 32'(IDLE));
        chk("midrst_rd_en",   32'(o_dbg_rd_en), 32'd0);
        chk("midrst_stall",   32'(o_pipe_stall), 32'd1);
        sb_q.delete();
        @(posedge clk);
        #1;
        i_rst_n = 1'b1;
        tick();

        // A dump after the reset starts again from register 0
        push_dump(32'd0);
        send_cmd(CMD_DUMP);
        wait_idle(100, "postrst_dump_idle", n);
        chk("postrst_all_words", 32'(sb_q.size()), 32'd0);

`ifdef PIPELINE_DEBUG_CYCLE_COUNT_EN
        // 10 RUN cycles + 4 drain cycles = 14 unstalled cycles
        send_cmd(CMD_RUN);
        repeat (9) tick();
        send_cmd(CMD_HALT);
        chk("cnt_drain_state", 32'(o_state), 32'(DRAIN));
        wait_idle(10, "cnt_drain_idle", n);
        push_dump(32'd14);
        send_cmd(CMD_DUMP);
        wait_idle(100, "cnt_dump_idle", n);
        chk("cnt_all_words", 32'(sb_q.size()), 32'd0);
`endif

        repeat (3) tick();
        chk("final_queue_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
